wb_write_queue: RTL and testbench

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

---
 rtl/wb_write_queue_if.sv | 43 ++++
 rtl/wb_write_queue.sv | 104 ++++++++++
 tb/tb_wb_write_queue.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: bus bundle between the pipeline / long-latency unit side
// (master) and the writeback queue (slave).
//   enq_*        : write-request handshake from the long-latency unit
//   pipe_wb_*    : pipeline writeback stage claim on the register-file port
//   regWrite/writeReg/writeData : register-file write port
//   lookup_*     : forwarding probe of pending queued writes
//   stall_req    : pipeline freeze request while the queue is starved
//   count        : number of occupied queue entries
interface wb_write_queue_if #(
    parameter int unsigned DEPTH = 4
);
    logic                     enq_valid;
    logic [4:0]               enq_reg;
    logic [31:0]              enq_data;
    logic                     enq_ready;
    logic                     pipe_wb_en;
    logic [4:0]               pipe_wb_reg;
    logic [31:0]              pipe_wb_data;
    logic                     regWrite;
    logic [4:0]               writeReg;
    logic [31:0]              writeData;
    logic [4:0]               lookup_reg;
    logic                     lookup_hit;
    logic [31:0]              lookup_data;
    logic                     stall_req;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output enq_valid, enq_reg, enq_data,
        output pipe_wb_en, pipe_wb_reg, pipe_wb_data,
        output lookup_reg,
        input  enq_ready, regWrite, writeReg, writeData,
        input  lookup_hit, lookup_data, stall_req, count
    );

    modport slave (
        input  enq_valid, enq_reg, enq_data,
        input  pipe_wb_en, pipe_wb_reg, pipe_wb_data,
        input  lookup_reg,
        output enq_ready, regWrite, writeReg, writeData,
        output lookup_hit, lookup_data, stall_req, count
    );
endinterface

// File: rtl/wb_write_queue.sv
// wb_write_queue: circular FIFO of pending register-file writes from a
// long-latency unit. Queued writes use the register-file port only on cycles
// the pipeline writeback stage leaves it idle. Provides a forwarding lookup
// (youngest pending write wins) and a starvation-driven pipeline stall.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-low reset
//   bus  : wb_write_queue_if.slave (handshake, write port, lookup, status)
module wb_write_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    wb_write_queue_if.slave   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIM + 1);

    logic [4:0]    regMem  [DEPTH];
    logic [31:0]   dataMem [DEPTH];
    logic [PW-1:0] head, tail, lkIdx;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve, starveNext;
    logic          stall;
    logic          full, empty, doEnq, doDeq;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    // Readiness depends only on current occupancy, never on a same-cycle dequeue.
    assign doEnq = bus.enq_valid && !full && (bus.enq_reg != 5'd0);
    assign doDeq = !bus.pipe_wb_en && !empty;

    assign bus.enq_ready = !full;
    assign bus.count     = cnt;
    assign bus.stall_req = stall;

    // Register-file port: pipeline has priority, queue head fills idle cycles.
    always_comb begin
        bus.regWrite  = 1'b0;
        bus.writeReg  = '0;
        bus.writeData = '0;
        if (bus.pipe_wb_en) begin
            bus.regWrite  = 1'b1;
            bus.writeReg  = bus.pipe_wb_reg;
            bus.writeData = bus.pipe_wb_data;
        end else if (!empty) begin
            bus.regWrite  = 1'b1;
            bus.writeReg  = regMem[head];
            bus.writeData = dataMem[head];
        end
    end

    // Walk occupied entries oldest to youngest; the last match is the youngest.
    always_comb begin
        bus.lookup_hit  = 1'b0;
        bus.lookup_data = '0;
        lkIdx           = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            lkIdx = head + PW'(i);
            if ((CW'(i) < cnt) && (bus.lookup_reg != 5'd0) &&
                (regMem[lkIdx] == bus.lookup_reg)) begin
                bus.lookup_hit  = 1'b1;
                bus.lookup_data = dataMem[lkIdx];
            end
        end
    end

    always_comb begin
        starveNext = '0;
        if (!empty && bus.pipe_wb_en) begin
            if (starve == SW'(STARVE_LIM)) starveNext = starve;
            else                           starveNext = starve + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            starve <= '0;
            stall  <= 1'b0;
        end else begin
            if (doEnq) tail <= tail + PW'(1);
            if (doDeq) head <= head + PW'(1);
            cnt    <= cnt + CW'(doEnq) - CW'(doDeq);
            starve <= starveNext;
            // Stall is sticky: it holds through the drain and drops only
            // after a cycle in which the queue was observed empty.
            if (starveNext == SW'(STARVE_LIM)) stall <= 1'b1;
            else if (empty)                    stall <= 1'b0;
        end
    end

    // Entry storage is not reset; occupancy alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (doEnq) begin
            regMem[tail]  <= bus.enq_reg;
            dataMem[tail] <= bus.enq_data;
        end
    end
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: randomized and directed self-checking bench for
// wb_write_queue against a queue-based reference model.
module tb_wb_write_queue;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned STARVE_LIM = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_write_queue_if #(.DEPTH(DEPTH)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   starveM = 0;
    bit   stallM  = 1'b0;
    int   passCnt = 0;
    int   checkCnt = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else passCnt++;
    endtask

    task automatic setIdle();
        rst              = 1'b1;
        bus.enq_valid    = 1'b0;
        bus.enq_reg      = '0;
        bus.enq_data     = '0;
        bus.pipe_wb_en   = 1'b0;
        bus.pipe_wb_reg  = '0;
        bus.pipe_wb_data = '0;
        bus.lookup_reg   = '0;
    endtask

    task automatic enq(input logic [4:0] r, input logic [31:0] d);
        bus.enq_valid = 1'b1;
        bus.enq_reg   = r;
        bus.enq_data  = d;
    endtask

    // Compare all outputs against the model, then advance one clock edge.
    task automatic step();
        logic        eWr, eHit;
        logic [4:0]  eReg;
        logic [31:0] eData, eLd;
        bit          deq, enqOk;
        int          sn;
        #1;
        eWr = 1'b0; eReg = '0; eData = '0;
        if (bus.pipe_wb_en) begin
            eWr = 1'b1; eReg = bus.pipe_wb_reg; eData = bus.pipe_wb_data;
        end else if (q.size() > 0) begin
            eWr = 1'b1; eReg = q[0].r; eData = q[0].d;
        end
        eHit = 1'b0; eLd = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (bus.lookup_reg != 5'd0 && q[i].r == bus.lookup_reg) begin
                eHit = 1'b1; eLd = q[i].d;
                break;
            end
        end
        checkVal("count",       32'(bus.count),     32'(q.size()));
        checkVal("enq_ready",   32'(bus.enq_ready), 32'(q.size() != DEPTH));
        checkVal("regWrite",    32'(bus.regWrite),  32'(eWr));
        checkVal("writeReg",    32'(bus.writeReg),  32'(eReg));
        checkVal("writeData",   bus.writeData,      eData);
        checkVal("lookup_hit",  32'(bus.lookup_hit), 32'(eHit));
        checkVal("lookup_data", bus.lookup_data,    eLd);
        checkVal("stall_req",   32'(bus.stall_req), 32'(stallM));
        @(posedge clk);
        if (!rst) begin
            q.delete();
            starveM = 0;
            stallM  = 1'b0;
        end else begin
            deq   = !bus.pipe_wb_en && q.size() > 0;
            enqOk = bus.enq_valid && q.size() != DEPTH && bus.enq_reg != 5'd0;
            if (q.size() == 0 || !bus.pipe_wb_en) sn = 0;
            else sn = (starveM + 1 > STARVE_LIM) ? STARVE_LIM : starveM + 1;
            if (sn == STARVE_LIM)  stallM = 1'b1;
            else if (q.size() == 0) stallM = 1'b0;
            starveM = sn;
            if (deq) void'(q.pop_front());
            if (enqOk) q.push_back('{r: bus.enq_reg, d: bus.enq_data});
        end
        #1;
    endtask

    task automatic doReset();
        setIdle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    int mode;

    initial begin
        setIdle();
        doReset();
        #1 checkVal("rst_count", 32'(bus.count), 0);
        checkVal("rst_ready", 32'(bus.enq_ready), 1);

        // Single enqueue, written the following cycle.
        enq(5'd5, 32'h1111_1111);
        step();
        bus.enq_valid = 1'b0;
        #1 checkVal("lat_regWrite", 32'(bus.regWrite), 1);
        checkVal("lat_writeReg", 32'(bus.writeReg), 5);
        checkVal("lat_writeData", bus.writeData, 32'h1111_1111);
        step();
        #1 checkVal("lat_count", 32'(bus.count), 0);

        // Fill under a busy pipeline, then drain in order.
        bus.pipe_wb_en = 1'b1;
        bus.pipe_wb_reg = 5'd20;
        bus.pipe_wb_data = 32'hDEAD_BEEF;
        for (int r = 1; r <= 4; r++) begin
            enq(5'(r), 32'h100 + 32'(r));
            step();
        end
        enq(5'd9, 32'h999);
        #1 checkVal("full_count", 32'(bus.count), 4);
        checkVal("full_ready", 32'(bus.enq_ready), 0);
        step();
        bus.enq_valid = 1'b0;
        bus.pipe_wb_en = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            #1 checkVal("drain_order", 32'(bus.writeReg), 32'(r));
            step();
        end
        #1 checkVal("drain_empty", 32'(bus.count), 0);

        // Lookup returns the youngest matching write.
        bus.pipe_wb_en = 1'b1;
        enq(5'd7, 32'hA); step();
        enq(5'd7, 32'hB); step();
        bus.enq_valid = 1'b0;
        bus.lookup_reg = 5'd7;
        #1 checkVal("lk_hit", 32'(bus.lookup_hit), 1);
        checkVal("lk_data", bus.lookup_data, 32'hB);
        bus.lookup_reg = 5'd0;
        #1 checkVal("lk_r0", 32'(bus.lookup_hit), 0);
        bus.pipe_wb_en = 1'b0;
        repeat (3) step();

        // Writes to r0 are swallowed.
        enq(5'd0, 32'h5555); step();
        bus.enq_valid = 1'b0;
        #1 checkVal("r0_count", 32'(bus.count), 0);
        checkVal("r0_regWrite", 32'(bus.regWrite), 0);
        step();

        // Starvation stall timing.
        doReset();
        bus.pipe_wb_en = 1'b1;
        enq(5'd3, 32'h33); step();
        bus.enq_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1 checkVal("stv_low", 32'(bus.stall_req), 0);
            step();
        end
        #1 checkVal("stv_high", 32'(bus.stall_req), 1);
        bus.pipe_wb_en = 1'b0;
        #1 checkVal("stv_wreg", 32'(bus.writeReg), 3);
        step();
        #1 checkVal("stv_hold", 32'(bus.stall_req), 1);
        step();
        #1 checkVal("stv_fall", 32'(bus.stall_req), 0);

        // Reset mid-operation discards pending entries.
        bus.pipe_wb_en = 1'b1;
        for (int r = 10; r <= 12; r++) begin
            enq(5'(r), 32'(r)); step();
        end
        enq(5'd13, 32'hD);
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.enq_valid = 1'b0;
        bus.pipe_wb_en = 1'b0;
        #1 checkVal("mid_count", 32'(bus.count), 0);
        checkVal("mid_ready", 32'(bus.enq_ready), 1);
        checkVal("mid_stall", 32'(bus.stall_req), 0);
        checkVal("mid_regWrite", 32'(bus.regWrite), 0);
        repeat (3) step();

        // Randomized traffic in bursts of busy/idle pipeline bias.
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) mode = $urandom_range(0, 2);
            rst              = ($urandom_range(0, 299) != 0);
            bus.enq_valid    = ($urandom_range(0, 2) != 0);
            bus.enq_reg      = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            bus.enq_data     = $urandom;
            case (mode)
                0:       bus.pipe_wb_en = ($urandom_range(0, 9) != 0);
                1:       bus.pipe_wb_en = ($urandom_range(0, 9) == 0);
                default: bus.pipe_wb_en = $urandom_range(0, 1) != 0;
            endcase
            bus.pipe_wb_reg  = 5'($urandom);
            bus.pipe_wb_data = $urandom;
            bus.lookup_reg   = 5'($urandom_range(0, 7));
            step();
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
